stack_based_alu: RTL and testbench
==================================

// Module: stack_based_alu
// PURPOSE
// - Parameterised LIFO-stack ALU: operands are pushed, then ADD/MUL consume the top two entries and push the result.
// - Signed two's-complement arithmetic with an overflow flag; registered outputs.
// - Used as a width-generic compute element: instanced at N = 4/8/16/32 side by side.
// PARAMETERS
// - N      default 16  data width in bits (legal >= 2)
// - DEPTH  default 8   stack entries (legal >= 2)
// PORTS
// - clk          in   1  single clock, all state on rising edge
// - rst          in   1  synchronous, active-high reset
// - opcode       in   3  operation, sampled every rising edge
// - input_data   in   N  signed operand for PUSH
// - output_data  out  N  registered result / popped value
// - overflow     out  1  registered signed-overflow flag of the last ADD/MUL
// BEHAVIOUR
// - Reset: stack emptied (sp=0), output_data=0, overflow=0; reset overrides any opcode in the same cycle.
// - Opcodes: 0xx NOP; 100 ADD; 101 MUL; 110 PUSH; 111 POP. One operation per clock; holding an opcode repeats it each cycle.
// - NOP: no state change, outputs hold.
// - PUSH: mem[sp]=input_data, sp++; output_data=input_data; overflow=0.
// - POP: output_data=mem[sp-1], sp--; overflow=0.
// - ADD: A=top, B=top-1; R=A+B truncated to N; pop both, push R (net sp-1); output_data=R;
//   overflow=1 iff A,B same sign and R sign differs.
// - MUL: full 2N signed product P=A*B; R=P[N-1:0]; pop both, push R; output_data=R;
//   overflow=1 iff P[2N-1:N-1] not all equal (P outside signed N range).
// - Latency: 1 cycle; outputs reflect the op sampled at the previous rising edge.
// - Boundaries: PUSH when sp==DEPTH -> ignored, outputs hold. POP when sp==0 -> ignored, outputs hold.
//   ADD/MUL with sp<2 -> ignored, stack unchanged, outputs hold.
// - Ignored operations set the error indication when STACK_ALU_STATUS_EN is defined (see CONFIGURATION).
// - sp range 0..DEPTH; no wrap-around. Stack contents are not cleared on POP, only sp moves.
// CONFIGURATION
// - Macro STACK_ALU_STATUS_EN defined: extra outputs empty (sp==0), full (sp==DEPTH), combinational from sp,
//   plus error (registered, 1 for the cycle after an ignored PUSH/POP/ADD/MUL, else 0, reset 0).
// - Not defined: these ports and the error register do not exist; ignored ops remain silent no-ops.
// STRUCTURE
// - Package stack_alu_pkg: opcode localparams OP_ADD=3'b100, OP_MUL=3'b101, OP_PUSH=3'b110, OP_POP=3'b111.
// - Package also holds the shared overflow-check function helpers.
// - Sub-module stack_alu_lifo (#(N,DEPTH)): register-array storage + sp, push/pop/replace-top2 controls, empty/full.
// - Top: opcode decode, operand fetch, adder/multiplier, overflow logic, output registers.
// TESTING
// - Reset then N=4: PUSH 4'b0011, PUSH 4'b0100, ADD -> output_data=4'b0111, overflow=0, sp=1.
// - N=8: PUSH 8'hEB (-21), PUSH 8'h0A, MUL -> P=-210, output_data=8'h2E, overflow=1.
// - N=16: PUSH 16'h3000, PUSH 16'h5FFE, ADD -> output_data=16'h8FFE, overflow=1.
// - N=32: PUSH 32'h00085FFF, PUSH 32'h0000000F, MUL -> output_data=32'h007D9FF1, overflow=0.
// - Edge: POP on empty, ADD with one entry, DEPTH+1 PUSHes -> ignored, outputs hold (error=1 if STATUS_EN).
// - Edge: POP after PUSH 5 -> output_data=5, sp back to 0.
// - Edge: rst asserted mid-sequence -> sp=0, output_data=0, overflow=0 on the next edge.

Source files
------------

// File: rtl/stack_alu_pkg.sv
// Shared opcode encodings and overflow helpers for the stack ALU.
package stack_alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    // Signed add overflow: operands agree in sign but the truncated sum does not.
    function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic r_sign);
        return (a_sign == b_sign) && (r_sign != a_sign);
    endfunction

    // Signed multiply overflow: bits [2N-1:N-1] of the product must be all ones or all zeros.
    function automatic logic mul_ovf(input logic upper_all_ones, input logic upper_any_one);
        return !(upper_all_ones || !upper_any_one);
    endfunction

endpackage

// File: rtl/stack_alu_lifo.sv
// Register-array LIFO with push, pop and replace-top-two controls plus occupancy flags.
module stack_alu_lifo
    import stack_alu_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         replace,
    input  logic [N-1:0] wr_data,
    output logic [N-1:0] top_data,
    output logic [N-1:0] next_data,
    output logic         empty,
    output logic         full,
    output logic         two_plus
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]   mem_r [DEPTH];
    logic [SPW-1:0] sp_r;
    logic [SPW-1:0] top_idx_s;
    logic [SPW-1:0] next_idx_s;

    assign top_idx_s  = sp_r - SPW'(1'b1);
    assign next_idx_s = sp_r - SPW'(2'd2);

    assign empty    = (sp_r == '0);
    assign full     = (sp_r == SPW'(DEPTH));
    assign two_plus = (sp_r >= SPW'(2'd2));

    assign top_data  = mem_r[top_idx_s[AW-1:0]];
    assign next_data = mem_r[next_idx_s[AW-1:0]];

    // Stack pointer: replace-top-two consumes two entries and pushes one, a net pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_r <= '0;
        end else if (push && !full) begin
            sp_r <= sp_r + SPW'(1'b1);
        end else if (pop && !empty) begin
            sp_r <= top_idx_s;
        end else if (replace && two_plus) begin
            sp_r <= top_idx_s;
        end else begin
            sp_r <= sp_r;
        end
    end

    // Storage writes; contents survive pops and reset, only the pointer moves.
    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            mem_r[sp_r[AW-1:0]] <= wr_data;
        end else if (!rst && replace && two_plus) begin
            mem_r[next_idx_s[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/stack_based_alu.sv
// Width-generic LIFO stack ALU (PUSH/POP/ADD/MUL) with registered result and overflow.
// Optional STACK_ALU_STATUS_EN adds empty/full flags and a registered error pulse for ignored ops.
module stack_based_alu
    import stack_alu_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   opcode,
    input  logic [N-1:0] input_data,
    output logic [N-1:0] output_data,
`ifdef STACK_ALU_STATUS_EN
    output logic         overflow,
    output logic         empty,
    output logic         full,
    output logic         error
`else
    output logic         overflow
`endif
);

    logic                  push_s;
    logic                  pop_s;
    logic                  replace_s;
    logic                  empty_s;
    logic                  full_s;
    logic                  two_plus_s;
    logic [N-1:0]          top_s;
    logic [N-1:0]          next_s;
    logic [N-1:0]          sum_s;
    logic [N-1:0]          result_s;
    logic [N-1:0]          wr_data_s;
    logic [2*N-1:0]        top_ext_s;
    logic [2*N-1:0]        next_ext_s;
    logic [2*N-1:0]        prod_s;
    logic                  arith_ovf_s;

    stack_alu_lifo #(.N(N), .DEPTH(DEPTH)) u_lifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .replace   (replace_s),
        .wr_data   (wr_data_s),
        .top_data  (top_s),
        .next_data (next_s),
        .empty     (empty_s),
        .full      (full_s),
        .two_plus  (two_plus_s)
    );

    // Decode against current occupancy so that out-of-range ops never reach the stack.
    always_comb begin
        push_s    = 1'b0;
        pop_s     = 1'b0;
        replace_s = 1'b0;
        case (opcode)
            OP_PUSH: begin
                if (!full_s) push_s = 1'b1;
                else         push_s = 1'b0;
            end
            OP_POP: begin
                if (!empty_s) pop_s = 1'b1;
                else          pop_s = 1'b0;
            end
            OP_ADD, OP_MUL: begin
                if (two_plus_s) replace_s = 1'b1;
                else            replace_s = 1'b0;
            end
            default: begin
                push_s = 1'b0;
            end
        endcase
    end

    assign top_ext_s  = {{N{top_s[N-1]}}, top_s};
    assign next_ext_s = {{N{next_s[N-1]}}, next_s};
    assign prod_s     = top_ext_s * next_ext_s;
    assign sum_s      = top_s + next_s;

    // Select the arithmetic result and its signed-overflow indication.
    always_comb begin
        if (opcode == OP_MUL) begin
            result_s    = prod_s[N-1:0];
            arith_ovf_s = mul_ovf(&prod_s[2*N-1:N-1], |prod_s[2*N-1:N-1]);
        end else begin
            result_s    = sum_s;
            arith_ovf_s = add_ovf(top_s[N-1], next_s[N-1], sum_s[N-1]);
        end
    end

    assign wr_data_s = push_s ? input_data : result_s;

    // Output registers; ignored ops and NOP leave both outputs untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            output_data <= '0;
            overflow    <= 1'b0;
        end else if (push_s) begin
            output_data <= input_data;
            overflow    <= 1'b0;
        end else if (pop_s) begin
            output_data <= top_s;
            overflow    <= 1'b0;
        end else if (replace_s) begin
            output_data <= result_s;
            overflow    <= arith_ovf_s;
        end else begin
            output_data <= output_data;
            overflow    <= overflow;
        end
    end

`ifdef STACK_ALU_STATUS_EN
    logic ignored_s;

    assign ignored_s = opcode[2] && !(push_s || pop_s || replace_s);
    assign empty     = empty_s;
    assign full      = full_s;

    // One-cycle error pulse following any non-NOP op the stack could not honour.
    always_ff @(posedge clk) begin
        if (rst) begin
            error <= 1'b0;
        end else begin
            error <= ignored_s;
        end
    end
`endif

endmodule

// File: tb/tb_stack_based_alu.sv
// Directed bench: four widths side by side against a queue-based reference model.
module tb_stack_based_alu;

    localparam int DEPTH = 8;
    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] ADD  = 3'b100;
    localparam logic [2:0] MUL  = 3'b101;
    localparam logic [2:0] PUSH = 3'b110;
    localparam logic [2:0] POP  = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op  [4];
    logic [31:0] din [4];
    logic [3:0]  out4;
    logic [7:0]  out8;
    logic [15:0] out16;
    logic [31:0] out32;
    logic [3:0]  ovf_v;
`ifdef STACK_ALU_STATUS_EN
    logic [3:0]  emp_v;
    logic [3:0]  ful_v;
    logic [3:0]  err_v;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          chk_en  = 1'b0;
    int          wid [4] = '{4, 8, 16, 32};

    longint      stk [4][$];
    longint      exp_out [4];
    bit          exp_ovf [4];
    bit          exp_err [4];

    always #5 clk = ~clk;

    stack_based_alu #(.N(4), .DEPTH(DEPTH)) u_n4 (
        .clk(clk), .rst(rst), .opcode(op[0]), .input_data(din[0][3:0]),
        .output_data(out4), .overflow(ovf_v[0])
`ifdef STACK_ALU_STATUS_EN
        , .empty(emp_v[0]), .full(ful_v[0]), .error(err_v[0])
`endif
    );
    stack_based_alu #(.N(8), .DEPTH(DEPTH)) u_n8 (
        .clk(clk), .rst(rst), .opcode(op[1]), .input_data(din[1][7:0]),
        .output_data(out8), .overflow(ovf_v[1])
`ifdef STACK_ALU_STATUS_EN
        , .empty(emp_v[1]), .full(ful_v[1]), .error(err_v[1])
`endif
    );
    stack_based_alu #(.N(16), .DEPTH(DEPTH)) u_n16 (
        .clk(clk), .rst(rst), .opcode(op[2]), .input_data(din[2][15:0]),
        .output_data(out16), .overflow(ovf_v[2])
`ifdef STACK_ALU_STATUS_EN
        , .empty(emp_v[2]), .full(ful_v[2]), .error(err_v[2])
`endif
    );
    stack_based_alu #(.N(32), .DEPTH(DEPTH)) u_n32 (
        .clk(clk), .rst(rst), .opcode(op[3]), .input_data(din[3]),
        .output_data(out32), .overflow(ovf_v[3])
`ifdef STACK_ALU_STATUS_EN
        , .empty(emp_v[3]), .full(ful_v[3]), .error(err_v[3])
`endif
    );

    function automatic longint sx(longint v, int w);
        longint t;
        t = v << (64 - w);
        return t >>> (64 - w);
    endfunction

    function automatic longint msk(longint v, int w);
        return v & ((longint'(1) << w) - longint'(1));
    endfunction

    function automatic longint act_out(int i);
        case (i)
            0:       return longint'(out4);
            1:       return longint'(out8);
            2:       return longint'(out16);
            default: return longint'(out32);
        endcase
    endfunction

    // Reference model: a plain queue per instance, arithmetic done in 64-bit and range-checked.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            longint a, b, r;
            if (rst) begin
                stk[i].delete();
                exp_out[i] = 0;
                exp_ovf[i] = 1'b0;
                exp_err[i] = 1'b0;
            end else begin
                exp_err[i] = 1'b0;
                case (op[i])
                    PUSH: begin
                        if (stk[i].size() < DEPTH) begin
                            stk[i].push_back(sx(longint'(din[i]), wid[i]));
                            exp_out[i] = msk(longint'(din[i]), wid[i]);
                            exp_ovf[i] = 1'b0;
                        end else exp_err[i] = 1'b1;
                    end
                    POP: begin
                        if (stk[i].size() > 0) begin
                            a = stk[i].pop_back();
                            exp_out[i] = msk(a, wid[i]);
                            exp_ovf[i] = 1'b0;
                        end else exp_err[i] = 1'b1;
                    end
                    ADD, MUL: begin
                        if (stk[i].size() >= 2) begin
                            a = stk[i].pop_back();
                            b = stk[i].pop_back();
                            r = (op[i] == ADD) ? a + b : a * b;
                            stk[i].push_back(sx(r, wid[i]));
                            exp_out[i] = msk(r, wid[i]);
                            exp_ovf[i] = (r != sx(r, wid[i]));
                        end else exp_err[i] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Compare every instance against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (act_out(i) != exp_out[i]) begin
                    n_fail++;
                    $display("FAIL output_data N=%0d t=%0t got=%h want=%h", wid[i], $time, act_out(i), exp_out[i]);
                end
                n_tests++;
                if (ovf_v[i] !== exp_ovf[i]) begin
                    n_fail++;
                    $display("FAIL overflow N=%0d t=%0t got=%b want=%b", wid[i], $time, ovf_v[i], exp_ovf[i]);
                end
`ifdef STACK_ALU_STATUS_EN
                n_tests++;
                if (err_v[i] !== exp_err[i] || emp_v[i] !== (stk[i].size() == 0) ||
                    ful_v[i] !== (stk[i].size() == DEPTH)) begin
                    n_fail++;
                    $display("FAIL status N=%0d t=%0t got err/emp/full=%b%b%b want err=%b size=%0d",
                             wid[i], $time, err_v[i], emp_v[i], ful_v[i], exp_err[i], stk[i].size());
                end
`endif
            end
        end
    end

    task automatic check_lit(input string name, input longint got, input longint want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step(input logic [2:0] o0, input logic [2:0] o1, input logic [2:0] o2,
                        input logic [2:0] o3, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
        op[0] = o0; op[1] = o1; op[2] = o2; op[3] = o3;
        din[0] = d0; din[1] = d1; din[2] = d2; din[3] = d3;
        @(negedge clk);
    endtask

    task automatic step_all(input logic [2:0] o, input logic [31:0] d);
        step(o, o, o, o, d, d, d, d);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op[i]  = NOP;
            din[i] = 32'h0;
        end
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check_lit("reset_out4", longint'(out4), 0);
        check_lit("reset_out32", longint'(out32), 0);
        check_lit("reset_ovf", longint'(ovf_v), 0);
        rst = 1'b0;

        step(PUSH, PUSH, PUSH, PUSH, 32'h3, 32'hEB, 32'h3000, 32'h00085FFF);
        step(PUSH, PUSH, PUSH, PUSH, 32'h4, 32'h0A, 32'h5FFE, 32'h0000000F);
        step(ADD, MUL, ADD, MUL, 32'h0, 32'h0, 32'h0, 32'h0);
        check_lit("n4_add", longint'(out4), 64'h7);
        check_lit("n4_ovf", longint'(ovf_v[0]), 0);
        check_lit("n8_mul", longint'(out8), 64'h2E);
        check_lit("n8_ovf", longint'(ovf_v[1]), 1);
        check_lit("n16_add", longint'(out16), 64'h8FFE);
        check_lit("n16_ovf", longint'(ovf_v[2]), 1);
        check_lit("n32_mul", longint'(out32), 64'h007D9FF1);
        check_lit("n32_ovf", longint'(ovf_v[3]), 0);

        // NOP holds, POP drains the single result, POP on empty is ignored.
        step_all(NOP, 32'h0);
        step_all(POP, 32'h0);
        check_lit("n4_pop_result", longint'(out4), 64'h7);
        step_all(POP, 32'h0);
        check_lit("n16_pop_empty_hold", longint'(out16), 64'h8FFE);

        // ADD with a single entry is ignored; POP then returns 5 and empties the stack.
        step_all(PUSH, 32'h5);
        step_all(ADD, 32'h0);
        check_lit("n8_add_one_entry_hold", longint'(out8), 64'h5);
        step_all(POP, 32'h0);
        step_all(POP, 32'h0);
        check_lit("n32_pop_after_push5", longint'(out32), 64'h5);

        // DEPTH+1 pushes: the last is ignored, top stays at the eighth value.
        for (int k = 1; k <= DEPTH + 1; k++) step_all(PUSH, 32'(k));
        check_lit("n16_full_push_hold", longint'(out16), 64'h8);
        step_all(POP, 32'h0);
        check_lit("n16_pop_after_full", longint'(out16), 64'h8);
        repeat (DEPTH) step_all(ADD, 32'h0);
        for (int k = 0; k < 4; k++) step_all(PUSH, 32'hFFFF_FFF9 + 32'(3 * k));
        repeat (5) step_all(MUL, 32'h0);

        // Reset mid-sequence overrides a concurrent PUSH.
        step_all(PUSH, 32'h1234_5677);
        rst = 1'b1;
        step_all(PUSH, 32'h7);
        rst = 1'b0;
        check_lit("midrst_out8", longint'(out8), 0);
        check_lit("midrst_ovf", longint'(ovf_v), 0);
        step_all(POP, 32'h0);
        check_lit("midrst_pop_empty", longint'(out32), 0);

        // Mixed traffic checked only by the model.
        for (int k = 0; k < 60; k++) begin
            step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 $urandom, $urandom, $urandom, $urandom);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
